round_ctrl: RTL and testbench

- Game-round controller that drives timer_smart from the other side of its interface. It issues t_start, t_length and t_freeze, and consumes t_done and t_flicker.
- Runs a fixed number of timed rounds. Each round ends on a player hit or on a timer expiry. Each new round is shorter than the last.
- Sits between the player inputs (go/pause/hit, already debounced to one-cycle pulses) and timer_smart. Drives the score/round display and a warning LED.

---
 rtl/round_ctrl_if.sv | 26 ++
 rtl/round_ctrl.sv | 102 ++++++++++
 tb/tb_round_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/round_ctrl_if.sv
// Signal bundle between round_ctrl, the player inputs and timer_smart.
// The slave modport is the controller's view; master is the surrounding system.
interface round_ctrl_if;
  logic       go;
  logic       pause;
  logic       hit;
  logic       t_done;
  logic       t_flicker;
  logic       t_start;
  logic [4:0] t_length;
  logic       t_freeze;
  logic       led_warn;
  logic [3:0] score;
  logic [2:0] round;
  logic       game_over;

  modport slave (
    input  go, pause, hit, t_done, t_flicker,
    output t_start, t_length, t_freeze, led_warn, score, round, game_over
  );

  modport master (
    output go, pause, hit, t_done, t_flicker,
    input  t_start, t_length, t_freeze, led_warn, score, round, game_over
  );
endinterface

// File: rtl/round_ctrl.sv
// Game-round controller: runs ROUNDS timed rounds against timer_smart,
// shrinking the timer length each round and counting player hits.
module round_ctrl #(
  parameter int ROUNDS    = 4,
  parameter int LEN_FIRST = 20,
  parameter int LEN_STEP  = 4,
  parameter int LEN_MIN   = 10
) (
  input  logic          clk,
  input  logic          reset,
  round_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_PAUSED, S_HIT, S_MISS, S_OVER
  } state_t;

  localparam logic [5:0] LP_FIRST     = 6'(LEN_FIRST);
  localparam logic [5:0] LP_STEP      = 6'(LEN_STEP);
  localparam logic [5:0] LP_MIN       = 6'(LEN_MIN);
  localparam logic [6:0] LP_THRESHOLD = 7'(LEN_MIN + LEN_STEP);
  localparam logic [2:0] LP_LAST      = 3'(ROUNDS - 1);

  state_t     r_state, w_state_next;
  logic [5:0] r_cur_len, w_cur_len_next;
  logic [4:0] r_t_length;
  logic [3:0] r_score, w_score_next;
  logic [2:0] r_round, w_round_next;
  logic       w_advance;

  always_comb begin
    w_state_next   = r_state;
    w_cur_len_next = r_cur_len;
    w_score_next   = r_score;
    w_round_next   = r_round;
    w_advance      = 1'b0;

    case (r_state)
      S_IDLE, S_OVER: begin
        if (bus.go) begin
          w_state_next   = S_ARM;
          w_score_next   = 4'd0;
          w_round_next   = 3'd0;
          w_cur_len_next = LP_FIRST;
        end
      end
      S_ARM:  w_state_next = S_RUN;
      S_RUN: begin
        // hit outranks a simultaneous expiry
        if (bus.hit)         w_state_next = S_HIT;
        else if (bus.t_done) w_state_next = S_MISS;
        else if (bus.pause)  w_state_next = S_PAUSED;
      end
      S_PAUSED: begin
        if (bus.t_done)     w_state_next = S_MISS;
        else if (bus.pause) w_state_next = S_RUN;
      end
      S_HIT: begin
        if (r_score != 4'd15) w_score_next = r_score + 4'd1;
        w_advance = 1'b1;
      end
      S_MISS: w_advance = 1'b1;
      default: w_state_next = S_IDLE;
    endcase

    if (w_advance) begin
      if (r_round == LP_LAST) begin
        w_state_next = S_OVER;
      end else begin
        w_state_next   = S_ARM;
        w_round_next   = r_round + 3'd1;
        w_cur_len_next = ({1'b0, r_cur_len} >= LP_THRESHOLD) ? (r_cur_len - LP_STEP) : LP_MIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cur_len  <= 6'd0;
      r_t_length <= 5'd0;
      r_score    <= 4'd0;
      r_round    <= 3'd0;
    end else begin
      r_state   <= w_state_next;
      r_cur_len <= w_cur_len_next;
      r_score   <= w_score_next;
      r_round   <= w_round_next;
      // latch the length on entry to ARM so it is valid alongside t_start
      if (w_state_next == S_ARM) r_t_length <= w_cur_len_next[4:0];
    end
  end

  assign bus.t_start   = (r_state == S_ARM);
  assign bus.t_freeze  = (r_state == S_PAUSED);
  assign bus.game_over = (r_state == S_OVER);
  assign bus.led_warn  = bus.t_flicker && (r_state == S_RUN);
  assign bus.t_length  = r_t_length;
  assign bus.score     = r_score;
  assign bus.round     = r_round;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: hit/miss rounds, length shrink and clamp,
// pause handling, simultaneous hit+expiry and mid-round reset.
module tb_round_ctrl;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  round_ctrl_if u_if ();

  round_ctrl #(
    .ROUNDS(4), .LEN_FIRST(20), .LEN_STEP(4), .LEN_MIN(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Snapshot of all registered/decoded outputs against expected values.
  task automatic chk_all(input string tag, input int st, input int len, input int frz,
                         input int sc, input int rd, input int go_);
    chk({tag, ".t_start"},   int'(u_if.t_start),   st);
    chk({tag, ".t_length"},  int'(u_if.t_length),  len);
    chk({tag, ".t_freeze"},  int'(u_if.t_freeze),  frz);
    chk({tag, ".score"},     int'(u_if.score),     sc);
    chk({tag, ".round"},     int'(u_if.round),     rd);
    chk({tag, ".game_over"}, int'(u_if.game_over), go_);
    $display("[TB] %s: t_start=%0d t_length=%0d t_freeze=%0d score=%0d round=%0d game_over=%0d",
             tag, u_if.t_start, u_if.t_length, u_if.t_freeze, u_if.score, u_if.round, u_if.game_over);
  endtask

  initial begin
    int exp_len [4];
    exp_len = '{20, 16, 12, 10};
    tests = 0;
    fails = 0;
    reset = 1'b1;
    u_if.go = 1'b0; u_if.pause = 1'b0; u_if.hit = 1'b0;
    u_if.t_done = 1'b0; u_if.t_flicker = 1'b0;

    // 1: reset then go
    repeat (5) tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.led_warn", int'(u_if.led_warn), 0);
    reset = 1'b0;
    tick();
    chk_all("idle", 0, 0, 0, 0, 0, 0);
    u_if.go = 1'b1; tick(); u_if.go = 1'b0;
    chk_all("go_arm", 1, 20, 0, 0, 0, 0);

    // 2: hit 3 cycles after each t_start
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("run.t_start", int'(u_if.t_start), 0);
      chk("run.t_length_hold", int'(u_if.t_length), exp_len[r]);
      tick(); tick();
      u_if.hit = 1'b1; tick(); u_if.hit = 1'b0;
      chk("hit.t_start", int'(u_if.t_start), 0);
      chk("hit.score", int'(u_if.score), r);
      tick();
      if (r < 3) chk_all("hit_next_arm", 1, exp_len[r+1], 0, r + 1, r + 1, 0);
      else       chk_all("hit_over", 0, 10, 0, 4, 3, 1);
    end
    repeat (3) tick();
    chk_all("over_idle", 0, 10, 0, 4, 3, 1);
    u_if.hit = 1'b1; u_if.pause = 1'b1; tick(); u_if.hit = 1'b0; u_if.pause = 1'b0;
    chk_all("over_ignore", 0, 10, 0, 4, 3, 1);

    // 3: misses via t_done
    u_if.go = 1'b1; tick(); u_if.go = 1'b0;
    chk_all("g2_arm", 1, 20, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      tick();
      u_if.t_done = 1'b1; tick(); u_if.t_done = 1'b0;
      chk("miss.t_start", int'(u_if.t_start), 0);
      tick();
      chk_all("miss_next_arm", 1, exp_len[r+1], 0, 0, r + 1, 0);
    end

    // 4: hit and t_done together count once as a hit
    tick();
    u_if.hit = 1'b1; u_if.t_done = 1'b1; tick(); u_if.hit = 1'b0; u_if.t_done = 1'b0;
    chk("both.t_start", int'(u_if.t_start), 0);
    tick();
    chk_all("both_arm", 1, 10, 0, 1, 3, 0);
    tick();
    chk("both.single_start", int'(u_if.t_start), 0);

    // 5: pause, ignored hit, resume, hit; led_warn only in RUN
    u_if.t_flicker = 1'b1; #1;
    chk("run.led_warn", int'(u_if.led_warn), 1);
    u_if.pause = 1'b1; tick(); u_if.pause = 1'b0;
    chk_all("paused", 0, 10, 1, 1, 3, 0);
    chk("paused.led_warn", int'(u_if.led_warn), 0);
    u_if.hit = 1'b1; tick(); u_if.hit = 1'b0;
    chk_all("paused_hit", 0, 10, 1, 1, 3, 0);
    u_if.pause = 1'b1; tick(); u_if.pause = 1'b0;
    chk_all("resumed", 0, 10, 0, 1, 3, 0);
    chk("resumed.led_warn", int'(u_if.led_warn), 1);
    u_if.t_flicker = 1'b0;
    u_if.hit = 1'b1; tick(); u_if.hit = 1'b0;
    tick();
    chk_all("pause_game_over", 0, 10, 0, 2, 3, 1);

    // 6: reset mid-round
    u_if.go = 1'b1; tick(); u_if.go = 1'b0;
    for (int r = 0; r < 2; r++) begin
      tick();
      u_if.hit = 1'b1; tick(); u_if.hit = 1'b0;
      tick();
    end
    tick();
    chk_all("pre_reset_run", 0, 12, 0, 2, 2, 0);
    u_if.t_flicker = 1'b1;
    reset = 1'b1; tick(); reset = 1'b0;
    chk_all("mid_reset", 0, 0, 0, 0, 0, 0);
    chk("mid_reset.led_warn", int'(u_if.led_warn), 0);
    u_if.t_flicker = 1'b0;
    u_if.go = 1'b1; tick(); u_if.go = 1'b0;
    chk_all("restart_arm", 1, 20, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
